split_n_module: RTL and testbench

SPLIT_N_MODULE -- requirements
Module: split_n_module

---
 rtl/kpn_pkg.sv | 13 +
 rtl/split_n_module_if.sv | 25 ++
 rtl/split_out_chan.sv | 36 +++
 rtl/split_n_module.sv | 115 +++++++++++
 tb/tb_split_n_module.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kpn_pkg.sv
// Shared KPN definitions: fork FSM state encoding and default token width.
package kpn_pkg;

  localparam int unsigned KPN_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_LATCH = 2'd2,
    ST_SEND  = 2'd3
  } split_state_e;

endpackage

// File: rtl/split_n_module_if.sv
// Upstream FIFO read port plus N downstream FIFO write ports of the KPN fork.
interface split_n_module_if #(
  parameter int WIDTH = kpn_pkg::KPN_DEFAULT_WIDTH,
  parameter int N_OUT = 2
);

  logic [WIDTH-1:0]       entry_1;
  logic                   in_empty;
  logic                   rd;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_full;
  logic [N_OUT-1:0]       wr;
  logic                   busy;

  modport master (
    input  entry_1, in_empty, out_full,
    output rd, out_data, wr, busy
  );

  modport slave (
    output entry_1, in_empty, out_full,
    input  rd, out_data, wr, busy
  );

endinterface

// File: rtl/split_out_chan.sv
// One fork output channel: tracks whether the current token is still owed to
// this channel and issues its single write strobe once the channel has room.
module split_out_chan (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic send,
  input  logic full,
  output logic wr,
  output logic pending
);

  logic wr_r;
  logic pending_r;

  // Pending bit and write strobe; a full channel keeps its token owed.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_r      <= 1'b0;
      pending_r <= 1'b0;
    end else if (load) begin
      wr_r      <= 1'b0;
      pending_r <= 1'b1;
    end else if (send) begin
      wr_r      <= pending_r & ~full;
      pending_r <= pending_r & full;
    end else begin
      wr_r      <= 1'b0;
      pending_r <= pending_r;
    end
  end

  assign wr      = wr_r;
  assign pending = pending_r;

endmodule

// File: rtl/split_n_module.sv
// KPN fork: reads each token once from upstream and writes it once to every
// output channel. Optional token_count output under SPLIT_TOKEN_COUNT_EN.
module split_n_module
  import kpn_pkg::*;
#(
  parameter int WIDTH = KPN_DEFAULT_WIDTH,
  parameter int N_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef SPLIT_TOKEN_COUNT_EN
  output logic [31:0] token_count,
`endif
  split_n_module_if.master io
);

  split_state_e     state_r;
  logic             rd_r;
  logic             busy_r;
  logic [WIDTH-1:0] hold_r;
  logic             load_s;
  logic             send_s;
  logic             all_done_s;
  logic [N_OUT-1:0] pending_s;
  logic [N_OUT-1:0] wr_s;

  assign load_s     = (state_r == ST_LATCH);
  assign send_s     = (state_r == ST_SEND);
  assign all_done_s = ~|pending_s;

  // Token sequencer: read request, wait for FIFO latency, latch, then fan out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      rd_r    <= 1'b0;
      busy_r  <= 1'b0;
      hold_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!io.in_empty) begin
            rd_r    <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_WAIT;
          end else begin
            rd_r    <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          rd_r    <= 1'b0;
          busy_r  <= 1'b1;
          state_r <= ST_LATCH;
        end
        ST_LATCH: begin
          rd_r    <= 1'b0;
          busy_r  <= 1'b1;
          hold_r  <= io.entry_1;
          state_r <= ST_SEND;
        end
        ST_SEND: begin
          rd_r <= 1'b0;
          if (all_done_s) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= ST_SEND;
          end
        end
        default: begin
          rd_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SPLIT_TOKEN_COUNT_EN
  logic [31:0] token_count_r;

  // Completed-token counter, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      token_count_r <= 32'd0;
    end else if (send_s && all_done_s) begin
      token_count_r <= token_count_r + 32'd1;
    end
  end

  assign token_count = token_count_r;
`endif

  // Each channel advances on its own full flag, so one stalled consumer
  // never holds back the others.
  for (genvar i = 0; i < N_OUT; i++) begin : g_chan
    split_out_chan u_chan (
      .clk     (clk),
      .reset   (reset),
      .load    (load_s),
      .send    (send_s),
      .full    (io.out_full[i]),
      .wr      (wr_s[i]),
      .pending (pending_s[i])
    );
  end

  assign io.rd       = rd_r;
  assign io.busy     = busy_r;
  assign io.wr       = wr_s;
  assign io.out_data = {N_OUT{hold_r}};

endmodule

// File: tb/tb_split_n_module.sv
// Directed bench for the KPN fork: a 2-channel and a 3-channel instance.
module tb_split_n_module;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  split_n_module_if #(.WIDTH(W), .N_OUT(2)) bus_a ();
  split_n_module_if #(.WIDTH(W), .N_OUT(3)) bus_b ();

`ifdef SPLIT_TOKEN_COUNT_EN
  logic [31:0] tc_a;
  logic [31:0] tc_b;
`endif

  split_n_module #(.WIDTH(W), .N_OUT(2)) dut_a (
    .clk         (clk),
    .reset       (reset),
`ifdef SPLIT_TOKEN_COUNT_EN
    .token_count (tc_a),
`endif
    .io          (bus_a.master)
  );

  split_n_module #(.WIDTH(W), .N_OUT(3)) dut_b (
    .clk         (clk),
    .reset       (reset),
`ifdef SPLIT_TOKEN_COUNT_EN
    .token_count (tc_b),
`endif
    .io          (bus_b.master)
  );

  int          checks;
  int          errors;
  logic [15:0] src_q [64];
  int          src_idx;
  int          src_n;
  bit          rand_full;
  logic [15:0] rx [2][32];
  int          rx_cnt [2];

  // One clock for both DUTs; models the upstream FIFO and downstream sinks of bus_a.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus_a.rd) begin
      bus_a.entry_1 = (src_idx < src_n) ? src_q[src_idx] : 16'hDEAD;
      src_idx++;
    end
    bus_a.in_empty = (src_idx >= src_n);
    for (int ch = 0; ch < 2; ch++) begin
      if (bus_a.wr[ch]) begin
        if (rx_cnt[ch] < 32) rx[ch][rx_cnt[ch]] = bus_a.out_data[ch*W +: W];
        rx_cnt[ch]++;
      end
    end
    if (rand_full) bus_a.out_full = 2'($urandom_range(0, 3));
  endtask

  task automatic load_tokens(input int n, input logic [15:0] base);
    for (int k = 0; k < n; k++) src_q[src_n + k] = base + 16'(k);
    src_n = src_n + n;
    bus_a.in_empty = 1'b0;
  endtask

  task automatic clear_rx();
    rx_cnt[0] = 0;
    rx_cnt[1] = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if ({bus_a.rd, bus_a.busy, bus_a.wr, bus_a.out_data} !== 36'd0) begin
      errors++;
      $display("FAIL reset_a: got rd=%b busy=%b wr=%b data=%h want all zero",
               bus_a.rd, bus_a.busy, bus_a.wr, bus_a.out_data);
    end
    checks++;
    if ({bus_b.rd, bus_b.busy, bus_b.wr, bus_b.out_data} !== 53'd0) begin
      errors++;
      $display("FAIL reset_b: got rd=%b busy=%b wr=%b data=%h want all zero",
               bus_b.rd, bus_b.busy, bus_b.wr, bus_b.out_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_rx();
    load_tokens(1, 16'h1234);
    step();
    checks++;
    if ({bus_a.rd, bus_a.busy} !== 2'b11) begin
      errors++;
      $display("FAIL basic_rd: got rd=%b busy=%b want 1 1", bus_a.rd, bus_a.busy);
    end
    step();
    checks++;
    if (bus_a.rd !== 1'b0) begin
      errors++;
      $display("FAIL basic_rd_pulse: got rd=%b want 0", bus_a.rd);
    end
    step();
    checks++;
    if (bus_a.wr !== 2'b00) begin
      errors++;
      $display("FAIL basic_early_wr: got %b want 00", bus_a.wr);
    end
    step();
    checks++;
    if ({bus_a.wr, bus_a.out_data} !== {2'b11, 16'h1234, 16'h1234}) begin
      errors++;
      $display("FAIL basic_wr: got wr=%b data=%h want 11 12341234", bus_a.wr, bus_a.out_data);
    end
    step();
    checks++;
    if ({bus_a.wr, bus_a.busy} !== 3'b000) begin
      errors++;
      $display("FAIL basic_done: got wr=%b busy=%b want 00 0", bus_a.wr, bus_a.busy);
    end
  endtask

  task automatic test_partial_full();
    bus_b.out_full = 3'b010;
    bus_b.entry_1  = 16'hABCD;
    bus_b.in_empty = 1'b0;
    step();
    checks++;
    if (bus_b.rd !== 1'b1) begin
      errors++;
      $display("FAIL part_rd: got %b want 1", bus_b.rd);
    end
    bus_b.in_empty = 1'b1;
    repeat (3) step();
    checks++;
    if ({bus_b.wr, bus_b.out_data} !== {3'b101, 16'hABCD, 16'hABCD, 16'hABCD}) begin
      errors++;
      $display("FAIL part_first_wr: got wr=%b data=%h want 101 abcdabcdabcd",
               bus_b.wr, bus_b.out_data);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if ({bus_b.wr, bus_b.busy} !== 4'b0001) begin
        errors++;
        $display("FAIL part_stall: cycle %0d got wr=%b busy=%b want 000 1", c, bus_b.wr, bus_b.busy);
      end
    end
    bus_b.out_full = 3'b000;
    step();
    checks++;
    if (bus_b.wr !== 3'b010) begin
      errors++;
      $display("FAIL part_late_wr: got %b want 010", bus_b.wr);
    end
    step();
    checks++;
    if ({bus_b.wr, bus_b.busy} !== 4'b0000) begin
      errors++;
      $display("FAIL part_done: got wr=%b busy=%b want 000 0", bus_b.wr, bus_b.busy);
    end
  endtask

  task automatic test_stream();
    bit done;
    done = 1'b0;
    clear_rx();
    load_tokens(16, 16'h0001);
    rand_full = 1'b1;
    for (int c = 0; c < 3000 && !done; c++) begin
      step();
      if (rx_cnt[0] >= 16 && rx_cnt[1] >= 16 && src_idx >= src_n && !bus_a.busy) done = 1'b1;
    end
    rand_full = 1'b0;
    bus_a.out_full = 2'b00;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL stream_timeout: got counts %0d/%0d want 16/16 within budget", rx_cnt[0], rx_cnt[1]);
    end
    for (int ch = 0; ch < 2; ch++) begin
      checks++;
      if (rx_cnt[ch] != 16) begin
        errors++;
        $display("FAIL stream_count: ch%0d got %0d tokens want 16", ch, rx_cnt[ch]);
      end
      for (int k = 0; k < 16 && k < rx_cnt[ch]; k++) begin
        checks++;
        if (rx[ch][k] !== 16'(k + 1)) begin
          errors++;
          $display("FAIL stream_order: ch%0d idx%0d got %h want %h", ch, k, rx[ch][k], 16'(k + 1));
        end
      end
    end
  endtask

  task automatic test_reset_in_send();
    clear_rx();
    bus_a.out_full = 2'b11;
    load_tokens(1, 16'h5A5A);
    repeat (3) step();
    checks++;
    if ({bus_a.busy, bus_a.wr} !== 3'b100) begin
      errors++;
      $display("FAIL rsend_pre: got busy=%b wr=%b want 1 00", bus_a.busy, bus_a.wr);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({bus_a.wr, bus_a.busy, bus_a.rd, bus_a.out_data} !== 36'd0) begin
      errors++;
      $display("FAIL rsend_reset: got wr=%b busy=%b rd=%b data=%h want all zero",
               bus_a.wr, bus_a.busy, bus_a.rd, bus_a.out_data);
    end
    reset = 1'b0;
    bus_a.out_full = 2'b00;
    repeat (10) step();
    checks++;
    if ({rx_cnt[0], rx_cnt[1], 31'd0, bus_a.busy} !== 96'd0) begin
      errors++;
      $display("FAIL rsend_discard: got writes %0d/%0d busy=%b want 0/0 0",
               rx_cnt[0], rx_cnt[1], bus_a.busy);
    end
  endtask

  task automatic test_stall();
    bus_a.out_full = 2'b11;
    load_tokens(1, 16'h0BEE);
    repeat (3) step();
    for (int c = 0; c < 100; c++) begin
      step();
      checks++;
      if ({bus_a.wr, bus_a.rd, bus_a.busy, bus_a.out_data} !== {2'b00, 1'b0, 1'b1, 16'h0BEE, 16'h0BEE}) begin
        errors++;
        $display("FAIL stall: cycle %0d got wr=%b rd=%b busy=%b data=%h want 00 0 1 0bee0bee",
                 c, bus_a.wr, bus_a.rd, bus_a.busy, bus_a.out_data);
      end
    end
    bus_a.out_full = 2'b00;
    step();
    checks++;
    if (bus_a.wr !== 2'b11) begin
      errors++;
      $display("FAIL stall_release: got wr=%b want 11", bus_a.wr);
    end
    step();
    checks++;
    if ({bus_a.wr, bus_a.busy} !== 3'b000) begin
      errors++;
      $display("FAIL stall_done: got wr=%b busy=%b want 00 0", bus_a.wr, bus_a.busy);
    end
  endtask

`ifdef SPLIT_TOKEN_COUNT_EN
  task automatic drain_a();
    for (int c = 0; c < 400; c++) begin
      if (src_idx >= src_n && !bus_a.busy) break;
      step();
    end
  endtask

  task automatic test_token_count();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (tc_a !== 32'd0) begin
      errors++;
      $display("FAIL tc_reset: got %h want 0", tc_a);
    end
    load_tokens(5, 16'h0100);
    drain_a();
    checks++;
    if (tc_a !== 32'd5) begin
      errors++;
      $display("FAIL tc_five: got %0d want 5", tc_a);
    end
    force dut_a.token_count_r = 32'hFFFF_FFFF;
    step();
    release dut_a.token_count_r;
    checks++;
    if (tc_a !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL tc_preload: got %h want ffffffff", tc_a);
    end
    load_tokens(1, 16'h0200);
    drain_a();
    checks++;
    if (tc_a !== 32'd0) begin
      errors++;
      $display("FAIL tc_wrap: got %h want 0", tc_a);
    end
  endtask
`endif

  initial begin
    checks         = 0;
    errors         = 0;
    src_idx        = 0;
    src_n          = 0;
    rand_full      = 1'b0;
    rx_cnt[0]      = 0;
    rx_cnt[1]      = 0;
    reset          = 1'b1;
    bus_a.entry_1  = 16'h0000;
    bus_a.in_empty = 1'b1;
    bus_a.out_full = 2'b00;
    bus_b.entry_1  = 16'h0000;
    bus_b.in_empty = 1'b1;
    bus_b.out_full = 3'b000;

    test_reset();
    test_basic();
    test_partial_full();
    test_stream();
    test_reset_in_send();
    test_stall();
`ifdef SPLIT_TOKEN_COUNT_EN
    test_token_count();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
